obi_addr_demux: RTL and testbench
=================================

// Module: obi_addr_demux
// PURPOSE
//  Splits one OBI data master (RI5CY data port or obi_arbiter output) onto two OBI slaves by address.
//  Inverse of obi_arbiter: one initiator in, two responders out. Sits between core/arbiter and
//  mm_ram (port A) plus a peripheral slave (port B).
//  Keeps responses in order by never having requests outstanding to two targets at once.
// PARAMETERS
//  ADDR_WIDTH       32            address width
//  DATA_WIDTH       32            data width; BE width = DATA_WIDTH/8
//  A_BASE           32'h0000_0000 port A region base
//  A_SIZE           32'h0010_0000 port A region size in bytes (A hit: A_BASE <= addr < A_BASE+A_SIZE)
//  B_BASE           32'h1000_0000 port B region base
//  B_SIZE           32'h0000_1000 port B region size in bytes
//  MAX_OUTSTANDING  2             max granted-but-unanswered transactions (>=1)
// PORTS
//  clk_i          in   1      clock
//  rst_ni         in   1      async reset, active low
//  s_req_i        in   1      upstream request
//  s_addr_i       in   AW     upstream address
//  s_we_i         in   1      upstream write enable
//  s_be_i         in   DW/8   upstream byte enables
//  s_wdata_i      in   DW     upstream write data
//  s_gnt_o        out  1      upstream grant
//  s_rvalid_o     out  1      upstream response valid
//  s_rdata_o      out  DW     upstream read data
//  s_err_o        out  1      upstream error response (tied 0 without OBI_DEMUX_ERR_EN)
//  m_addr_o/m_we_o/m_be_o/m_wdata_o  out  AW/1/DW/8/DW  shared payload to both slaves = s_* inputs
//  m_req_a_o      out  1      request to port A
//  m_gnt_a_i      in   1      grant from port A
//  m_rvalid_a_i   in   1      response valid from port A
//  m_rdata_a_i    in   DW     read data from port A
//  m_req_b_o / m_gnt_b_i / m_rvalid_b_i / m_rdata_b_i   same as A, for port B
// BEHAVIOUR
//  - Decode (comb): tgt = A on A hit, B on B hit, else B (or ERR with macro). A wins on overlap.
//  - State: cnt (0..MAX_OUTSTANDING, width $clog2(MAX_OUTSTANDING+1)), last_tgt. Reset: cnt=0, last_tgt=A.
//  - allowed = (cnt==0 || tgt==last_tgt) && cnt<MAX_OUTSTANDING, all from registered cnt/last_tgt.
//  - m_req_x_o = s_req_i & allowed & (tgt==x); s_gnt_o = gnt of selected target & allowed. Zero added latency.
//  - Handshake hs = s_req_i & s_gnt_o: cnt+1, last_tgt<=tgt. Response rsp = s_rvalid_o: cnt-1.
//    hs and rsp same cycle: cnt unchanged. Slot freed by rsp usable the following cycle only.
//  - s_rvalid_o = rvalid of last_tgt port & (cnt!=0); s_rdata_o muxed from last_tgt port, 0 when !s_rvalid_o.
//    rvalid from non-last_tgt port, or any rvalid at cnt==0, is dropped (assertion fires in sim).
//  - Target switch: new-target request stalled (gnt 0, m_req 0) until cnt==0; forwarded next cycle.
//  - Request held without gnt is OBI-compliant upstream; demux does not latch payload.
//  - Reset outputs: all m_req_*, s_gnt_o, s_rvalid_o, s_err_o = 0 (req low; cnt=0).
//  - Reset mid-operation: outstanding transactions discarded; late slave rvalids after release ignored.
// CONFIGURATION
//  OBI_DEMUX_ERR_EN defined: unmapped address -> internal ERR target; granted same cycle when allowed,
//   err_pend flop gives s_rvalid_o=1, s_err_o=1, s_rdata_o=32'hBADC_AB1E next cycle; no slave sees it;
//   ERR counts as a target for cnt/switch rules; back-to-back errors one per cycle.
//  Not defined: unmapped addresses routed to port B; s_err_o constant 0; no err_pend flop.
// STRUCTURE
//  obi_demux_pkg: typedef enum logic [1:0] {TGT_A, TGT_B, TGT_ERR} obi_tgt_e; ERR_RDATA constant.
//  Sub-module obi_demux_tracker: cnt/last_tgt/err_pend registers, outputs allowed and last_tgt.
//  Top: address decode, request/grant steering, response mux.
// TESTING
//  1 read 0x0000_0100, A gnt same cycle, A rvalid +2 with 0x1234_5678 -> s_rdata_o=0x1234_5678, cnt 1->0.
//  2 three A writes back-to-back, A rvalid delayed 4 cycles, MAX=2 -> 3rd s_gnt_o=0 until cycle after 1st rvalid.
//  3 A read outstanding, then read 0x1000_0004 -> m_req_b_o=0 until cycle after A rvalid, then 1.
//  4 cnt=1, new A gnt and A rvalid same cycle -> cnt stays 1, s_rvalid_o=1.
//  5 rst_ni low at cnt=2, release, m_rvalid_a_i=1 -> s_rvalid_o=0, cnt=0.
//  6 read 0x2000_0000: ERR_EN -> s_gnt_o same cycle, next s_rvalid_o=1,s_err_o=1,rdata 0xBADCAB1E; else m_req_b_o=1.

Source files
------------

// File: rtl/obi_demux_pkg.sv
// Shared types for the OBI address demultiplexer.
// Target encoding and the error-response read data pattern.
package obi_demux_pkg;

    typedef enum logic [1:0] {
        TGT_A,
        TGT_B,
        TGT_ERR
    } obi_tgt_e;

    localparam logic [31:0] ERR_RDATA = 32'hBADC_AB1E;

endpackage

// File: rtl/obi_demux_tracker.sv
// Outstanding-transaction tracker: count, last target, error pending.
// Optional macro OBI_DEMUX_ERR_EN adds the err_pend flop.
module obi_demux_tracker
    import obi_demux_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_tgt_e tgt_i,
    input  logic     hs_i,
    input  logic     rsp_i,
    output logic     allowed_o,
    output obi_tgt_e last_tgt_o,
    output logic     busy_o,
    output logic     err_pend_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    obi_tgt_e      last_tgt_q, last_tgt_d;

    // Next-state: count grants minus responses, remember last granted target
    always_comb begin
        cnt_d      = cnt_q;
        last_tgt_d = last_tgt_q;
        if (hs_i && !rsp_i) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!hs_i && rsp_i) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (hs_i) begin
            last_tgt_d = tgt_i;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            last_tgt_q <= TGT_A;
        end else begin
            cnt_q      <= cnt_d;
            last_tgt_q <= last_tgt_d;
        end
    end

`ifdef OBI_DEMUX_ERR_EN
    logic err_pend_q, err_pend_d;

    // Error response is produced exactly one cycle after its grant
    always_comb begin
        err_pend_d = hs_i && (tgt_i == TGT_ERR);
    end

    // Error-pending register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_pend_q <= 1'b0;
        end else begin
            err_pend_q <= err_pend_d;
        end
    end

    assign err_pend_o = err_pend_q;
`else
    assign err_pend_o = 1'b0;
`endif

    // Only the current target may be granted while anything is in flight
    always_comb begin
        allowed_o = ((cnt_q == '0) || (tgt_i == last_tgt_q))
                    && (cnt_q < CW'(MAX_OUTSTANDING));
    end

    assign last_tgt_o = last_tgt_q;
    assign busy_o     = (cnt_q != '0);

endmodule

// File: rtl/obi_addr_demux.sv
// OBI 1-to-2 address demux with in-order responses.
// Optional macro OBI_DEMUX_ERR_EN answers unmapped addresses internally.
module obi_addr_demux
    import obi_demux_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] A_BASE          = 'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] A_SIZE          = 'h0010_0000,
    parameter logic [ADDR_WIDTH-1:0] B_BASE          = 'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] B_SIZE          = 'h0000_1000,
    parameter int unsigned           MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    s_req_i,
    input  logic [ADDR_WIDTH-1:0]   s_addr_i,
    input  logic                    s_we_i,
    input  logic [DATA_WIDTH/8-1:0] s_be_i,
    input  logic [DATA_WIDTH-1:0]   s_wdata_i,
    output logic                    s_gnt_o,
    output logic                    s_rvalid_o,
    output logic [DATA_WIDTH-1:0]   s_rdata_o,
    output logic                    s_err_o,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic                    m_we_o,
    output logic [DATA_WIDTH/8-1:0] m_be_o,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic                    m_req_a_o,
    input  logic                    m_gnt_a_i,
    input  logic                    m_rvalid_a_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_a_i,
    output logic                    m_req_b_o,
    input  logic                    m_gnt_b_i,
    input  logic                    m_rvalid_b_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_b_i
);

    obi_tgt_e              tgt;
    obi_tgt_e              last_tgt;
    logic                  allowed;
    logic                  busy;
    logic                  err_pend;
    logic                  hs;
    logic                  tgt_gnt;
    logic                  rv_sel;
    logic [DATA_WIDTH-1:0] rd_sel;
    logic [ADDR_WIDTH-1:0] a_off;
    logic [ADDR_WIDTH-1:0] b_off;
    logic                  a_hit;
    logic                  b_hit;

    // Region decode via offsets so base+size never overflows
    always_comb begin
        a_off = s_addr_i - A_BASE;
        b_off = s_addr_i - B_BASE;
        a_hit = (s_addr_i >= A_BASE) && (a_off < A_SIZE);
        b_hit = (s_addr_i >= B_BASE) && (b_off < B_SIZE);
        if (a_hit) begin
            tgt = TGT_A;
        end else if (b_hit) begin
            tgt = TGT_B;
        end else begin
`ifdef OBI_DEMUX_ERR_EN
            tgt = TGT_ERR;
`else
            tgt = TGT_B;
`endif
        end
    end

    obi_demux_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_trk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .tgt_i      (tgt),
        .hs_i       (hs),
        .rsp_i      (s_rvalid_o),
        .allowed_o  (allowed),
        .last_tgt_o (last_tgt),
        .busy_o     (busy),
        .err_pend_o (err_pend)
    );

    // Request steering and grant return; the ERR target grants itself
    always_comb begin
        m_req_a_o = s_req_i && allowed && (tgt == TGT_A);
        m_req_b_o = s_req_i && allowed && (tgt == TGT_B);
        case (tgt)
            TGT_A:   tgt_gnt = m_gnt_a_i;
            TGT_B:   tgt_gnt = m_gnt_b_i;
            default: tgt_gnt = 1'b1;
        endcase
        s_gnt_o = tgt_gnt && allowed;
        hs      = s_req_i && s_gnt_o;
    end

    assign m_addr_o  = s_addr_i;
    assign m_we_o    = s_we_i;
    assign m_be_o    = s_be_i;
    assign m_wdata_o = s_wdata_i;

    // Response mux: only the last granted target may answer
    always_comb begin
        case (last_tgt)
            TGT_A: begin
                rv_sel = m_rvalid_a_i;
                rd_sel = m_rdata_a_i;
            end
            TGT_B: begin
                rv_sel = m_rvalid_b_i;
                rd_sel = m_rdata_b_i;
            end
            default: begin
                rv_sel = err_pend;
                rd_sel = DATA_WIDTH'(ERR_RDATA);
            end
        endcase
        s_rvalid_o = rv_sel && busy;
        s_rdata_o  = s_rvalid_o ? rd_sel : '0;
        s_err_o    = s_rvalid_o && (last_tgt == TGT_ERR);
    end

`ifndef SYNTHESIS
    // Flag slave responses that arrive with nothing outstanding to them
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(m_rvalid_a_i && !(busy && last_tgt == TGT_A)))
            else $warning("obi_addr_demux: stray rvalid on port A dropped");
            assert (!(m_rvalid_b_i && !(busy && last_tgt == TGT_B)))
            else $warning("obi_addr_demux: stray rvalid on port B dropped");
        end
    end
`endif

endmodule

// File: tb/tb_obi_addr_demux.sv
// Directed testbench for obi_addr_demux.
// Honors OBI_DEMUX_ERR_EN for the unmapped-address scenarios.
module tb_obi_addr_demux;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        s_req_i;
    logic [31:0] s_addr_i;
    logic        s_we_i;
    logic [3:0]  s_be_i;
    logic [31:0] s_wdata_i;
    logic        s_gnt_o;
    logic        s_rvalid_o;
    logic [31:0] s_rdata_o;
    logic        s_err_o;
    logic [31:0] m_addr_o;
    logic        m_we_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_wdata_o;
    logic        m_req_a_o;
    logic        m_gnt_a_i;
    logic        m_rvalid_a_i;
    logic [31:0] m_rdata_a_i;
    logic        m_req_b_o;
    logic        m_gnt_b_i;
    logic        m_rvalid_b_i;
    logic [31:0] m_rdata_b_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    obi_addr_demux dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .s_req_i      (s_req_i),
        .s_addr_i     (s_addr_i),
        .s_we_i       (s_we_i),
        .s_be_i       (s_be_i),
        .s_wdata_i    (s_wdata_i),
        .s_gnt_o      (s_gnt_o),
        .s_rvalid_o   (s_rvalid_o),
        .s_rdata_o    (s_rdata_o),
        .s_err_o      (s_err_o),
        .m_addr_o     (m_addr_o),
        .m_we_o       (m_we_o),
        .m_be_o       (m_be_o),
        .m_wdata_o    (m_wdata_o),
        .m_req_a_o    (m_req_a_o),
        .m_gnt_a_i    (m_gnt_a_i),
        .m_rvalid_a_i (m_rvalid_a_i),
        .m_rdata_a_i  (m_rdata_a_i),
        .m_req_b_o    (m_req_b_o),
        .m_gnt_b_i    (m_gnt_b_i),
        .m_rvalid_b_i (m_rvalid_b_i),
        .m_rdata_b_i  (m_rdata_b_i)
    );

    wire [1:0] cnt = dut.u_trk.cnt_q;

    task automatic idle();
        s_req_i      = 1'b0;
        s_addr_i     = '0;
        s_we_i       = 1'b0;
        s_be_i       = 4'hF;
        s_wdata_i    = '0;
        m_gnt_a_i    = 1'b0;
        m_rvalid_a_i = 1'b0;
        m_rdata_a_i  = '0;
        m_gnt_b_i    = 1'b0;
        m_rvalid_b_i = 1'b0;
        m_rdata_b_i  = '0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (m_req_a_o !== 1'b0 || m_req_b_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req got a=%b b=%b exp 0 0", m_req_a_o, m_req_b_o);
        end
        n_tests++;
        if (s_gnt_o !== 1'b0 || s_rvalid_o !== 1'b0 || s_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_resp got gnt=%b rv=%b err=%b exp 0 0 0",
                     s_gnt_o, s_rvalid_o, s_err_o);
        end
        n_tests++;
        if (cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_cnt got %0d exp 0", cnt);
        end
    endtask

    task automatic test_single_read();
        step();
        s_req_i = 1'b1; s_addr_i = 32'h0000_0100; m_gnt_a_i = 1'b1;
        #2;
        n_tests++;
        if (m_req_a_o !== 1'b1 || m_req_b_o !== 1'b0 || s_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_req got a=%b b=%b gnt=%b exp 1 0 1",
                     m_req_a_o, m_req_b_o, s_gnt_o);
        end
        n_tests++;
        if (m_addr_o !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL rd_addr got %h exp 00000100", m_addr_o);
        end
        step();
        idle();
        #2;
        n_tests++;
        if (cnt !== 2'd1 || s_rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wait got cnt=%0d rv=%b exp 1 0", cnt, s_rvalid_o);
        end
        step();
        m_rvalid_a_i = 1'b1; m_rdata_a_i = 32'h1234_5678;
        #2;
        n_tests++;
        if (s_rvalid_o !== 1'b1 || s_rdata_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL rd_data got rv=%b d=%h exp 1 12345678",
                     s_rvalid_o, s_rdata_o);
        end
        step();
        idle();
        #2;
        n_tests++;
        if (cnt !== 2'd0 || s_rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_done got cnt=%0d d=%h exp 0 0", cnt, s_rdata_o);
        end
    endtask

    task automatic test_max_outstanding();
        step();
        s_req_i = 1'b1; s_we_i = 1'b1; s_addr_i = 32'h200; m_gnt_a_i = 1'b1;
        #2;
        n_tests++;
        if (s_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL max_g0 got %b exp 1", s_gnt_o);
        end
        step();
        s_addr_i = 32'h204;
        #2;
        n_tests++;
        if (s_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL max_g1 got %b exp 1", s_gnt_o);
        end
        step();
        s_addr_i = 32'h208;
        #2;
        n_tests++;
        if (s_gnt_o !== 1'b0 || m_req_a_o !== 1'b0 || cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL max_stall got gnt=%b req=%b cnt=%0d exp 0 0 2",
                     s_gnt_o, m_req_a_o, cnt);
        end
        step();
        #2;
        n_tests++;
        if (s_gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL max_stall2 got %b exp 0", s_gnt_o);
        end
        step();
        m_rvalid_a_i = 1'b1;
        #2;
        n_tests++;
        if (s_rvalid_o !== 1'b1 || s_gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL max_rsp got rv=%b gnt=%b exp 1 0", s_rvalid_o, s_gnt_o);
        end
        step();
        m_rvalid_a_i = 1'b0;
        #2;
        n_tests++;
        if (s_gnt_o !== 1'b1 || cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL max_free got gnt=%b cnt=%0d exp 1 1", s_gnt_o, cnt);
        end
        step();
        idle();
        m_rvalid_a_i = 1'b1;
        step();
        m_rvalid_a_i = 1'b1;
        step();
        idle();
        #2;
        n_tests++;
        if (cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL max_drain got cnt=%0d exp 0", cnt);
        end
    endtask

    task automatic test_switch();
        step();
        s_req_i = 1'b1; s_addr_i = 32'h100; m_gnt_a_i = 1'b1;
        step();
        idle();
        s_req_i = 1'b1; s_addr_i = 32'h1000_0004; m_gnt_b_i = 1'b1;
        #2;
        n_tests++;
        if (m_req_b_o !== 1'b0 || s_gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_stall got req=%b gnt=%b exp 0 0", m_req_b_o, s_gnt_o);
        end
        step();
        m_rvalid_a_i = 1'b1; m_rdata_a_i = 32'hAAAA_0001;
        #2;
        n_tests++;
        if (m_req_b_o !== 1'b0 || s_rvalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_rsp got req=%b rv=%b exp 0 1", m_req_b_o, s_rvalid_o);
        end
        step();
        m_rvalid_a_i = 1'b0;
        #2;
        n_tests++;
        if (m_req_b_o !== 1'b1 || m_req_a_o !== 1'b0 || s_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_fwd got b=%b a=%b gnt=%b exp 1 0 1",
                     m_req_b_o, m_req_a_o, s_gnt_o);
        end
        step();
        idle();
        m_rvalid_b_i = 1'b1; m_rdata_b_i = 32'hCAFE_0001;
        #2;
        n_tests++;
        if (s_rvalid_o !== 1'b1 || s_rdata_o !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL sw_bdata got rv=%b d=%h exp 1 cafe0001",
                     s_rvalid_o, s_rdata_o);
        end
        step();
        idle();
    endtask

    task automatic test_simultaneous();
        step();
        s_req_i = 1'b1; s_addr_i = 32'h300; m_gnt_a_i = 1'b1;
        step();
        m_rvalid_a_i = 1'b1; m_rdata_a_i = 32'h0000_BEEF;
        #2;
        n_tests++;
        if (s_gnt_o !== 1'b1 || s_rvalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_both got gnt=%b rv=%b exp 1 1", s_gnt_o, s_rvalid_o);
        end
        step();
        idle();
        #2;
        n_tests++;
        if (cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL sim_cnt got %0d exp 1", cnt);
        end
        m_rvalid_a_i = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        step();
        s_req_i = 1'b1; s_addr_i = 32'h400; m_gnt_a_i = 1'b1;
        step();
        step();
        idle();
        #2;
        n_tests++;
        if (cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL rm_pre got cnt=%0d exp 2", cnt);
        end
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL rm_async got cnt=%0d exp 0", cnt);
        end
        step();
        rst_ni = 1'b1;
        m_rvalid_a_i = 1'b1; m_rdata_a_i = 32'h5555_5555;
        #2;
        n_tests++;
        if (s_rvalid_o !== 1'b0 || s_rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_late got rv=%b d=%h exp 0 0", s_rvalid_o, s_rdata_o);
        end
        step();
        idle();
        #2;
        n_tests++;
        if (cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL rm_cnt got %0d exp 0", cnt);
        end
    endtask

    task automatic test_decode();
        step();
        s_req_i = 1'b1; s_addr_i = 32'h000F_FFFC;
        #2;
        n_tests++;
        if (m_req_a_o !== 1'b1 || m_req_b_o !== 1'b0) begin
            n_fail++;
            $display("FAIL dec_atop got a=%b b=%b exp 1 0", m_req_a_o, m_req_b_o);
        end
        s_addr_i = 32'h1000_0FFC;
        #1;
        n_tests++;
        if (m_req_a_o !== 1'b0 || m_req_b_o !== 1'b1) begin
            n_fail++;
            $display("FAIL dec_btop got a=%b b=%b exp 0 1", m_req_a_o, m_req_b_o);
        end
        s_addr_i = 32'h0010_0000;
        #1;
`ifdef OBI_DEMUX_ERR_EN
        n_tests++;
        if (m_req_a_o !== 1'b0 || m_req_b_o !== 1'b0 || s_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL dec_aend got a=%b b=%b gnt=%b exp 0 0 1",
                     m_req_a_o, m_req_b_o, s_gnt_o);
        end
        step();
        idle();
        step();
`else
        n_tests++;
        if (m_req_a_o !== 1'b0 || m_req_b_o !== 1'b1) begin
            n_fail++;
            $display("FAIL dec_aend got a=%b b=%b exp 0 1", m_req_a_o, m_req_b_o);
        end
`endif
        idle();
    endtask

    task automatic test_unmapped();
        step();
        s_req_i = 1'b1; s_addr_i = 32'h2000_0000;
`ifdef OBI_DEMUX_ERR_EN
        #2;
        n_tests++;
        if (s_gnt_o !== 1'b1 || m_req_a_o !== 1'b0 || m_req_b_o !== 1'b0) begin
            n_fail++;
            $display("FAIL um_gnt got gnt=%b a=%b b=%b exp 1 0 0",
                     s_gnt_o, m_req_a_o, m_req_b_o);
        end
        step();
        idle();
        #2;
        n_tests++;
        if (s_rvalid_o !== 1'b1 || s_err_o !== 1'b1 || s_rdata_o !== 32'hBADC_AB1E) begin
            n_fail++;
            $display("FAIL um_err got rv=%b err=%b d=%h exp 1 1 badcab1e",
                     s_rvalid_o, s_err_o, s_rdata_o);
        end
`else
        m_gnt_b_i = 1'b1;
        #2;
        n_tests++;
        if (m_req_b_o !== 1'b1 || m_req_a_o !== 1'b0 || s_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL um_b got b=%b a=%b gnt=%b exp 1 0 1",
                     m_req_b_o, m_req_a_o, s_gnt_o);
        end
        step();
        idle();
        m_rvalid_b_i = 1'b1; m_rdata_b_i = 32'h0BAD_0002;
        #2;
        n_tests++;
        if (s_rvalid_o !== 1'b1 || s_err_o !== 1'b0 || s_rdata_o !== 32'h0BAD_0002) begin
            n_fail++;
            $display("FAIL um_rsp got rv=%b err=%b d=%h exp 1 0 0bad0002",
                     s_rvalid_o, s_err_o, s_rdata_o);
        end
`endif
        step();
        idle();
        #2;
        n_tests++;
        if (cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL um_cnt got %0d exp 0", cnt);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        rst_ni = 1'b1;
        test_single_read();
        test_max_outstanding();
        test_switch();
        test_simultaneous();
        test_decode();
        test_unmapped();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
